// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready input and level or
// fixed-length pulse output; out-of-range codes are accepted and flagged on err.
module onehot_decoder_seq #(
    parameter int IN_W      = 3,
    parameter int OUT_W     = 8,
    parameter int PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  i,
    input  logic             mode,
    input  logic             clr,
    output logic [OUT_W-1:0] y,
    output logic             out_valid,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam int unsigned OUT_WU = OUT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [OUT_W-1:0]   y_n;
    logic               err_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [OUT_W-1:0]   dec;
    logic               in_range;
    logic               accept;

    // Handshake: a code transfers on any rising edge where in_valid and
    // in_ready are both high; in_ready never depends on in_valid, and is low
    // under rst, under clr, and for the whole active pulse.
    assign in_ready  = ~rst & ~clr & (state != PULSE);
    assign accept    = in_valid & in_ready;
    assign out_valid = |y;
    assign state_dbg = state;

    // Shifting past the top bit yields zero, so out-of-range codes decode to 0.
    assign in_range = (32'(i) < OUT_WU);
    assign dec      = OUT_W'(1) << i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            y     <= y_n;
            err   <= err_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        y_n     = y;
        err_n   = 1'b0;
        cnt_n   = cnt;
        if (clr) begin
            state_n = IDLE;
            y_n     = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                PULSE: begin
                    // cnt counts the remaining active cycles including this one.
                    if (cnt <= CNT_W'(1)) begin
                        state_n = IDLE;
                        y_n     = '0;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        if (in_range) begin
                            y_n     = dec;
                            state_n = mode ? PULSE : HOLD;
                            cnt_n   = mode ? CNT_W'(PULSE_LEN) : '0;
                        end else begin
                            y_n     = '0;
                            err_n   = 1'b1;
                            state_n = IDLE;
                            cnt_n   = '0;
                        end
                    end
                end
            endcase
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) $countones(y) <= 1);
    a_idle_zero: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (y == '0));
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt <= CNT_W'(PULSE_LEN));

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: a 6-output instance for handshake,
// level, pulse, range and clear behaviour, and an 8-output instance swept over all codes.
module tb_onehot_decoder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] i = '0;
    logic       mode = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] y;
    logic       out_valid;
    logic       err;
    logic [1:0] state_dbg;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [2:0] i8 = '0;
    logic       mode8 = 1'b0;
    logic       clr8 = 1'b0;
    logic [7:0] y8;
    logic       out_valid8;
    logic       err8;
    logic [1:0] state_dbg8;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp8;

    always #5 clk = ~clk;

    onehot_decoder_seq #(.IN_W(3), .OUT_W(6), .PULSE_LEN(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i(i), .mode(mode), .clr(clr), .y(y), .out_valid(out_valid),
        .err(err), .state_dbg(state_dbg)
    );

    onehot_decoder_seq #(.IN_W(3), .OUT_W(8), .PULSE_LEN(3)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .i(i8), .mode(mode8), .clr(clr8), .y(y8), .out_valid(out_valid8),
        .err(err8), .state_dbg(state_dbg8)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    initial begin
        // reset
        step;
        look;
        chk("rst_y", y, 0); chk("rst_ov", out_valid, 0);
        chk("rst_err", err, 0); chk("rst_ready", in_ready, 0);
        step;
        look;
        chk("rst2_ready", in_ready, 0); chk("rst2_state", state_dbg, 0);
        step;
        rst = 1'b0;
        look;
        chk("rel_ready", in_ready, 1); chk("rel_y", y, 0);
        step;

        // level mode, replaced without a zero gap
        in_valid = 1'b1; i = 3'd5; mode = 1'b0;
        look;
        chk("lvl_ready", in_ready, 1);
        step;
        for (int k = 1; k <= 10; k++) begin
            in_valid = (k == 5); i = 3'd0; mode = 1'b0;
            look;
            chk("lvl_y", y, (k <= 5) ? 6'b100000 : 6'b000001);
            chk("lvl_ov", out_valid, 1);
            step;
        end
        look;
        chk("lvl_state", state_dbg, 1);
        step;

        // pulse mode with in_valid held high
        in_valid = 1'b1; i = 3'd2; mode = 1'b1;
        look;
        chk("pls_ready0", in_ready, 1);
        step;
        for (int k = 1; k <= 8; k++) begin
            in_valid = (k <= 4);
            look;
            chk("pls_y", y, ((k >= 1 && k <= 3) || (k >= 5 && k <= 7)) ? 6'b000100 : 6'b000000);
            chk("pls_ready", in_ready, (k == 4 || k == 8) ? 1 : 0);
            if (k == 1) chk("pls_state", state_dbg, 2);
            step;
        end

        // out-of-range codes
        in_valid = 1'b1; i = 3'd7; mode = 1'b0;
        step;
        in_valid = 1'b0;
        look;
        chk("oor7_y", y, 0); chk("oor7_ov", out_valid, 0); chk("oor7_err", err, 1);
        step;
        look;
        chk("oor7_err_drop", err, 0);
        step;
        in_valid = 1'b1; i = 3'd6; mode = 1'b1;
        step;
        in_valid = 1'b0;
        look;
        chk("oor6_err", err, 1); chk("oor6_y", y, 0); chk("oor6_ready", in_ready, 1);
        step;
        in_valid = 1'b1; i = 3'd5; mode = 1'b0;
        step;
        in_valid = 1'b0;
        look;
        chk("top_y", y, 6'b100000); chk("top_err", err, 0);
        step;

        // clr aborting a pulse
        in_valid = 1'b1; i = 3'd1; mode = 1'b1;
        step;
        in_valid = 1'b0;
        look;
        chk("clrp_y1", y, 6'b000010);
        step;
        clr = 1'b1;
        look;
        chk("clrp_ready", in_ready, 0); chk("clrp_y2", y, 6'b000010);
        step;
        clr = 1'b0;
        look;
        chk("clrp_y3", y, 0); chk("clrp_ov3", out_valid, 0); chk("clrp_ready3", in_ready, 1);
        step;

        // clr with in_valid in HOLD accepts nothing
        in_valid = 1'b1; i = 3'd3; mode = 1'b0;
        step;
        clr = 1'b1; in_valid = 1'b1; i = 3'd4;
        look;
        chk("clrh_ready", in_ready, 0); chk("clrh_y", y, 6'b001000);
        step;
        clr = 1'b0; in_valid = 1'b0;
        look;
        chk("clrh_y2", y, 0); chk("clrh_ov2", out_valid, 0);
        step;
        look;
        chk("clrh_y3", y, 0);
        step;

        // rst aborting a pulse
        in_valid = 1'b1; i = 3'd4; mode = 1'b1;
        step;
        in_valid = 1'b0; rst = 1'b1;
        look;
        chk("rstp_ready", in_ready, 0); chk("rstp_y", y, 6'b010000);
        step;
        rst = 1'b0;
        look;
        chk("rstp_y2", y, 0); chk("rstp_ready2", in_ready, 1);
        step;

        // all codes, both modes, on the full-width instance
        for (int c = 0; c < 8; c++) begin
            for (int m = 0; m < 2; m++) begin
                exp8 = 8'b1;
                exp8 = exp8 << c;
                in_valid8 = 1'b1; i8 = 3'(c); mode8 = m[0];
                look;
                chk("sw_ready", in_ready8, 1);
                step;
                in_valid8 = 1'b0;
                look;
                chk("sw_y", y8, exp8);
                chk("sw_onehot", $countones(y8), 1);
                chk("sw_err", err8, 0);
                step;
                if (m == 1) begin
                    step;
                    step;
                    look;
                    chk("sw_pulse_end", y8, 0);
                    step;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
